// File: rtl/tlb_pkg.sv
// Shared encodings for the TLB operation controller: op codes, CP0 selects,
// packed TLB entry field offsets, CP0 register bit positions and FSM states.
package tlb_pkg;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'b00,
    OP_TLBR  = 2'b01,
    OP_TLBWI = 2'b10,
    OP_TLBWR = 2'b11
  } tlb_op_e;

  typedef enum logic [1:0] {
    SEL_INDEX    = 2'd0,
    SEL_ENTRYHI  = 2'd1,
    SEL_ENTRYLO0 = 2'd2,
    SEL_ENTRYLO1 = 2'd3
  } cp0_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned VPN2_W = 19;
  localparam int unsigned ASID_W = 8;
  localparam int unsigned PFN_W  = 20;
  localparam int unsigned C_W    = 3;

  // Packed entry {vpn2,asid,g,pfn0,c0,d0,v0,pfn1,c1,d1,v1}, LSB first below.
  localparam int unsigned ENTRY_W    = 78;
  localparam int unsigned E_V1       = 0;
  localparam int unsigned E_D1       = 1;
  localparam int unsigned E_C1_LSB   = 2;
  localparam int unsigned E_PFN1_LSB = 5;
  localparam int unsigned E_V0       = 25;
  localparam int unsigned E_D0       = 26;
  localparam int unsigned E_C0_LSB   = 27;
  localparam int unsigned E_PFN0_LSB = 30;
  localparam int unsigned E_G        = 50;
  localparam int unsigned E_ASID_LSB = 51;
  localparam int unsigned E_VPN2_LSB = 59;

  localparam int unsigned EHI_VPN2_LSB = 13;
  localparam logic [31:0] EHI_WMASK    = 32'hFFFF_E0FF;

  localparam int unsigned ELO_G       = 0;
  localparam int unsigned ELO_V       = 1;
  localparam int unsigned ELO_D       = 2;
  localparam int unsigned ELO_C_LSB   = 3;
  localparam int unsigned ELO_PFN_LSB = 6;
  localparam logic [31:0] ELO_WMASK   = 32'h03FF_FFFF;

  function automatic logic [31:0] make_entrylo(input logic [PFN_W-1:0] pfn,
                                               input logic [C_W-1:0]   c,
                                               input logic d, input logic v,
                                               input logic g);
    return {6'b0, pfn, c, d, v, g};
  endfunction

endpackage

// File: rtl/tlb_random_ctr.sv
// CP0 Random register: free-running down counter that wraps 0 -> TLBNUM-1.
module tlb_random_ctr #(
  parameter  int unsigned TLBNUM = 16,
  localparam int unsigned IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [IDXW-1:0] random_o
);

  logic [IDXW-1:0] random_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 random_q <= IDXW'(TLBNUM - 1);
    else if (random_q == '0)   random_q <= IDXW'(TLBNUM - 1);
    else                       random_q <= random_q - 1'b1;
  end

  assign random_o = random_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// Executes TLBP/TLBR/TLBWI/TLBWR against the TLB and owns the CP0 TLB registers.
// Optional macro TLB_RANDOM_EN adds the Random register used as the TLBWR index.
module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter  int unsigned TLBNUM = 16,
  localparam int unsigned IDXW   = $clog2(TLBNUM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [1:0]         req_op,
  output logic               req_ready,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               busy,
  input  logic               cp0_we,
  input  logic [1:0]         cp0_sel,
  input  logic [31:0]        cp0_wdata,
  output logic [31:0]        index_o,
  output logic [31:0]        entryhi_o,
  output logic [31:0]        entrylo0_o,
  output logic [31:0]        entrylo1_o,
  output logic [VPN2_W-1:0]  s_vpn2,
  output logic [ASID_W-1:0]  s_asid,
  input  logic               s_found,
  input  logic [IDXW-1:0]    s_index,
  output logic               tlb_we,
  output logic [IDXW-1:0]    w_index,
  output logic [ENTRY_W-1:0] w_entry,
  output logic [IDXW-1:0]    r_index,
  input  logic [ENTRY_W-1:0] r_entry
);

  state_e          state_q, state_d;
  tlb_op_e         op_q, op_d;
  logic            index_p_q, index_p_d;
  logic [IDXW-1:0] index_q, index_d;
  logic [31:0]     entryhi_q, entryhi_d;
  logic [31:0]     entrylo0_q, entrylo0_d;
  logic [31:0]     entrylo1_q, entrylo1_d;

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // the asynchronous reset also clears the registers so a cut-off op leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_TLBP;
      index_p_q  <= 1'b0;
      index_q    <= '0;
      entryhi_q  <= '0;
      entrylo0_q <= '0;
      entrylo1_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      index_p_q  <= index_p_d;
      index_q    <= index_d;
      entryhi_q  <= entryhi_d;
      entrylo0_q <= entrylo0_d;
      entrylo1_q <= entrylo1_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    index_p_d  = index_p_q;
    index_d    = index_q;
    entryhi_d  = entryhi_q;
    entrylo0_d = entrylo0_q;
    entrylo1_d = entrylo1_q;
    tlb_we     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A CP0 write and a request accepted together both land on this edge.
        if (cp0_we) begin
          unique case (cp0_sel_e'(cp0_sel))
            SEL_INDEX:    index_d    = cp0_wdata[IDXW-1:0];
            SEL_ENTRYHI:  entryhi_d  = cp0_wdata & EHI_WMASK;
            SEL_ENTRYLO0: entrylo0_d = cp0_wdata & ELO_WMASK;
            SEL_ENTRYLO1: entrylo1_d = cp0_wdata & ELO_WMASK;
            default: ;
          endcase
        end
        if (req_valid) begin
          op_d    = tlb_op_e'(req_op);
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_RESP;
        unique case (op_q)
          OP_TLBP: begin
            index_p_d = ~s_found;
            index_d   = s_found ? s_index : '0;
          end
          OP_TLBR: begin
            entryhi_d  = {r_entry[E_VPN2_LSB +: VPN2_W], 5'b0, r_entry[E_ASID_LSB +: ASID_W]};
            entrylo0_d = make_entrylo(r_entry[E_PFN0_LSB +: PFN_W], r_entry[E_C0_LSB +: C_W],
                                      r_entry[E_D0], r_entry[E_V0], r_entry[E_G]);
            entrylo1_d = make_entrylo(r_entry[E_PFN1_LSB +: PFN_W], r_entry[E_C1_LSB +: C_W],
                                      r_entry[E_D1], r_entry[E_V1], r_entry[E_G]);
          end
          OP_TLBWI, OP_TLBWR: tlb_we = 1'b1;
          default: ;
        endcase
      end

      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_entry = '0;
    w_entry[E_VPN2_LSB +: VPN2_W] = entryhi_q[EHI_VPN2_LSB +: VPN2_W];
    w_entry[E_ASID_LSB +: ASID_W] = entryhi_q[ASID_W-1:0];
    w_entry[E_G]                  = entrylo0_q[ELO_G] & entrylo1_q[ELO_G];
    w_entry[E_PFN0_LSB +: PFN_W]  = entrylo0_q[ELO_PFN_LSB +: PFN_W];
    w_entry[E_C0_LSB +: C_W]      = entrylo0_q[ELO_C_LSB +: C_W];
    w_entry[E_D0]                 = entrylo0_q[ELO_D];
    w_entry[E_V0]                 = entrylo0_q[ELO_V];
    w_entry[E_PFN1_LSB +: PFN_W]  = entrylo1_q[ELO_PFN_LSB +: PFN_W];
    w_entry[E_C1_LSB +: C_W]      = entrylo1_q[ELO_C_LSB +: C_W];
    w_entry[E_D1]                 = entrylo1_q[ELO_D];
    w_entry[E_V1]                 = entrylo1_q[ELO_V];
  end

`ifdef TLB_RANDOM_EN
  logic [IDXW-1:0] random_w;

  tlb_random_ctr #(.TLBNUM(TLBNUM)) u_random (
    .clk      (clk),
    .reset    (reset),
    .random_o (random_w)
  );

  assign w_index = (op_q == OP_TLBWR) ? random_w : index_q;
`else
  assign w_index = index_q;
`endif

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign r_index    = index_q;
  assign s_vpn2     = entryhi_q[EHI_VPN2_LSB +: VPN2_W];
  assign s_asid     = entryhi_q[ASID_W-1:0];
  assign index_o    = {index_p_q, {(31 - IDXW){1'b0}}, index_q};
  assign entryhi_o  = entryhi_q;
  assign entrylo0_o = entrylo0_q;
  assign entrylo1_o = entrylo1_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Self-checking bench for tlb_op_ctrl: directed cases plus randomized ops
// against a register-level reference model (Random modelled as cycle count mod 16).
module tb_tlb_op_ctrl;

  localparam int TLBNUM = 16;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, resp_valid, resp_ready, busy;
  logic [1:0]  req_op;
  logic        cp0_we;
  logic [1:0]  cp0_sel;
  logic [31:0] cp0_wdata;
  logic [31:0] index_o, entryhi_o, entrylo0_o, entrylo1_o;
  logic [18:0] s_vpn2;
  logic [7:0]  s_asid;
  logic        s_found;
  logic [3:0]  s_index;
  logic        tlb_we;
  logic [3:0]  w_index, r_index;
  logic [77:0] w_entry, r_entry;

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .busy(busy),
    .cp0_we(cp0_we), .cp0_sel(cp0_sel), .cp0_wdata(cp0_wdata),
    .index_o(index_o), .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o),
    .s_vpn2(s_vpn2), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
    .tlb_we(tlb_we), .w_index(w_index), .w_entry(w_entry),
    .r_index(r_index), .r_entry(r_entry)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; Random in any cycle is (15 - cyc) mod 16.
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [77:0] got, input logic [77:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] m_idx, m_ehi, m_lo0, m_lo1;

  function automatic void model_write(input logic [1:0] sel, input logic [31:0] d);
    case (sel)
      2'd0: m_idx = {m_idx[31], 27'b0, d[3:0]};
      2'd1: m_ehi = {d[31:13], 5'b0, d[7:0]};
      2'd2: m_lo0 = {6'b0, d[25:0]};
      default: m_lo1 = {6'b0, d[25:0]};
    endcase
  endfunction

  function automatic ent_t model_went();
    ent_t e;
    e.vpn2 = m_ehi[31:13];  e.asid = m_ehi[7:0];
    e.g    = m_lo0[0] & m_lo1[0];
    e.pfn0 = m_lo0[25:6];   e.c0 = m_lo0[5:3];  e.d0 = m_lo0[2];  e.v0 = m_lo0[1];
    e.pfn1 = m_lo1[25:6];   e.c1 = m_lo1[5:3];  e.d1 = m_lo1[2];  e.v1 = m_lo1[1];
    return e;
  endfunction

  task automatic check_regs(input string tag);
    check({tag, "_index"},   index_o,    m_idx);
    check({tag, "_entryhi"}, entryhi_o,  m_ehi);
    check({tag, "_lo0"},     entrylo0_o, m_lo0);
    check({tag, "_lo1"},     entrylo1_o, m_lo1);
  endtask

  // Called in IDLE, #1 after a rising edge; returns #1 after the edge back into IDLE.
  task automatic cp0_write(input logic [1:0] sel, input logic [31:0] d);
    cp0_we = 1'b1; cp0_sel = sel; cp0_wdata = d;
    @(posedge clk); #1;
    cp0_we = 1'b0;
    model_write(sel, d);
  endtask

  task automatic run_op(input logic [1:0] op, input int stall, input bit with_wr,
                        input logic [1:0] wsel, input logic [31:0] wdata,
                        input logic found, input logic [3:0] sidx, input ent_t rent);
    logic [3:0] exp_widx;
    logic [3:0] exp_rand;
    exp_rand = 4'(14 - cyc);
    check("idle_req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op;
    if (with_wr) begin cp0_we = 1'b1; cp0_sel = wsel; cp0_wdata = wdata; end
    @(negedge clk);
    check("accept_cycle_we", tlb_we, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0; cp0_we = 1'b0;
    if (with_wr) model_write(wsel, wdata);
    s_found = found; s_index = sidx; r_entry = rent;
    @(negedge clk);
    check("exec_busy", busy, 1'b1);
    check("exec_resp_valid", resp_valid, 1'b0);
    check("exec_req_ready", req_ready, 1'b0);
    check("exec_tlb_we", tlb_we, op[1]);
    if (op[1]) begin
`ifdef TLB_RANDOM_EN
      exp_widx = (op == 2'b11) ? exp_rand : m_idx[3:0];
`else
      exp_widx = m_idx[3:0];
`endif
      check("w_index", w_index, exp_widx);
      check("w_entry", w_entry, model_went());
    end else if (op == 2'b01) begin
      check("r_index", r_index, m_idx[3:0]);
      m_ehi = {rent.vpn2, 5'b0, rent.asid};
      m_lo0 = {6'b0, rent.pfn0, rent.c0, rent.d0, rent.v0, rent.g};
      m_lo1 = {6'b0, rent.pfn1, rent.c1, rent.d1, rent.v1, rent.g};
    end else begin
      check("s_vpn2", s_vpn2, m_ehi[31:13]);
      check("s_asid", s_asid, m_ehi[7:0]);
      m_idx = found ? {28'b0, sidx} : 32'h8000_0000;
    end
    @(posedge clk); #1;
    s_found = 1'b0; r_entry = '0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_resp_valid", resp_valid, 1'b1);
      check("stall_req_ready", req_ready, 1'b0);
      check("stall_tlb_we", tlb_we, 1'b0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("resp_valid", resp_valid, 1'b1);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("back_idle_busy", busy, 1'b0);
    check_regs("post_op");
  endtask

  ent_t        ent;
  ent_t        zero_ent;
  logic [95:0] rnd;
  logic [31:0] ehi_before;

  initial begin
    zero_ent = '0;
    reset = 1'b1;
    req_valid = 1'b0; req_op = 2'b00; resp_ready = 1'b0;
    cp0_we = 1'b0; cp0_sel = 2'd0; cp0_wdata = '0;
    s_found = 1'b0; s_index = '0; r_entry = '0;
    m_idx = '0; m_ehi = '0; m_lo0 = '0; m_lo1 = '0;
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_tlb_we", tlb_we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check_regs("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // TLBWI with the documented register contents
    cp0_write(2'd1, 32'h0000_4005);
    cp0_write(2'd2, 32'h0000_0047);
    cp0_write(2'd3, 32'h0000_0086);
    cp0_write(2'd0, 32'h0000_0003);
    check("wi_entryhi", entryhi_o, 32'h0000_4005);
    run_op(2'b10, 0, 1'b0, 2'd0, '0, 1'b0, 4'd0, zero_ent);

    // TLBP hit then miss
    run_op(2'b00, 1, 1'b0, 2'd0, '0, 1'b1, 4'd3, zero_ent);
    check("tlbp_hit_index", index_o, 32'h0000_0003);
    run_op(2'b00, 0, 1'b0, 2'd0, '0, 1'b0, 4'd7, zero_ent);
    check("tlbp_miss_index", index_o, 32'h8000_0000);

    // TLBR with G set; Index written in the same cycle the request is accepted
    ent = '{vpn2: 19'd2, asid: 8'd5, g: 1'b1, pfn0: 20'd1, c0: 3'd3, d0: 1'b1, v0: 1'b1,
            pfn1: 20'd0, c1: 3'd0, d1: 1'b0, v1: 1'b0};
    run_op(2'b01, 0, 1'b1, 2'd0, 32'h0000_0003, 1'b0, 4'd0, ent);
    check("tlbr_entryhi", entryhi_o, 32'h0000_4005);
    check("tlbr_lo0", entrylo0_o, 32'h0000_005F);
    check("tlbr_lo1_g", entrylo1_o[0], 1'b1);

    // TLBWR: aim the EXEC cycle at Random = 9, 0 and then 15 (wrap)
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < TLBNUM && 4'(14 - cyc) != ((t == 0) ? 4'd9 : (t == 1) ? 4'd0 : 4'd15); k++) begin
        @(posedge clk); #1;
      end
      run_op(2'b11, 0, 1'b0, 2'd0, '0, 1'b0, 4'd0, zero_ent);
    end

    // Backpressure: RESP held 5 cycles while a request and an EntryHi write are offered
    ehi_before = m_ehi;
    req_valid = 1'b1; req_op = 2'b10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b00;
    cp0_we = 1'b1; cp0_sel = 2'd1; cp0_wdata = 32'hDEAD_BEEF;
    repeat (5) begin
      @(negedge clk);
      check("bp_resp_valid", resp_valid, 1'b1);
      check("bp_req_ready", req_ready, 1'b0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; cp0_we = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    check("bp_resp_valid_release", resp_valid, 1'b1);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("bp_not_accepted", busy, 1'b0);
    check("bp_entryhi_kept", entryhi_o, ehi_before);

    // Reset during EXEC of TLBWI
    @(posedge clk); #1;
    cp0_write(2'd2, 32'h0000_0047);
    req_valid = 1'b1; req_op = 2'b10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_we", tlb_we, 1'b1);
    #2 reset = 1'b1;
    #1;
    m_idx = '0; m_ehi = '0; m_lo0 = '0; m_lo1 = '0;
    check("mid_rst_we", tlb_we, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check_regs("mid_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_resp_valid", resp_valid, 1'b0);
      check("post_rst_req_ready", req_ready, 1'b1);
    end
    @(posedge clk); #1;
    run_op(2'b11, 0, 1'b0, 2'd0, '0, 1'b0, 4'd0, zero_ent);

    // Randomized operation mix
    for (int it = 0; it < 60; it++) begin
      int nwr;
      nwr = $urandom_range(0, 2);
      for (int w = 0; w < nwr; w++) cp0_write(2'($urandom_range(0, 3)), $urandom);
      rnd = {$urandom, $urandom, $urandom};
      ent = rnd[77:0];
      run_op(2'($urandom_range(0, 3)), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
             2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), ent);
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
Controller that executes TLB management operations (TLBP, TLBR, TLBWI, TLBWR) against the 16-entry dual-search TLB.
- Owns the CP0 TLB registers: Index, EntryHi, EntryLo0, EntryLo1, and optionally Random.
- Drives the TLB's search port 1, read port and write port.
- Sits between the writeback/CP0 stage and the TLB, accepting one operation at a time over a valid/ready handshake.

Parameters:
- TLBNUM, 16, number of TLB entries. Local IDXW = $clog2(TLBNUM).

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  operation request
- req_op  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
- req_ready  out  1  high only in IDLE
- resp_valid  out  1  operation complete; held until resp_ready
- resp_ready  in  1  consumer accepts completion
- busy  out  1  state != IDLE
- cp0_we  in  1  software write to a TLB CP0 register
- cp0_sel  in  2  0 Index, 1 EntryHi, 2 EntryLo0, 3 EntryLo1
- cp0_wdata  in  32  write data
- index_o / entryhi_o / entrylo0_o / entrylo1_o  out  32 each  current register values
- s_vpn2  out  19  search key = EntryHi[31:13]
- s_asid  out  8  = EntryHi[7:0]
- s_found  in  1  search hit
- s_index  in  IDXW  hit index
- tlb_we  out  1  single-cycle write strobe
- w_index  out  IDXW  write index
- w_entry  out  78  packed {vpn2,asid,g,pfn0,c0,d0,v0,pfn1,c1,d1,v1}
- r_index  out  IDXW  = Index[IDXW-1:0]
- r_entry  in  78  packed read data, same layout

Behaviour:
- Register formats:
  - EntryHi: VPN2[31:13], ASID[7:0]; other bits read 0.
  - EntryLo: PFN[25:6], C[5:3], D[2], V[1], G[0]; bits 31:26 read 0.
  - Index: P[31], index[IDXW-1:0]; other bits read 0.
- cp0 writes:
  - Apply only the defined bits; Index.P is not software-writable.
  - Accepted only in IDLE; dropped otherwise. Callers gate on busy.
- Reset: state IDLE. All registers 0, resp_valid 0, tlb_we 0, req_ready 1.
- FSM IDLE -> EXEC -> RESP -> IDLE.
  - IDLE: req_valid && req_ready latches op; next state EXEC.
  - EXEC (one cycle): perform the op; next state RESP.
  - RESP: resp_valid=1. Leave for IDLE on resp_ready. resp_valid and resp_ready may both be high in the cycle RESP is entered.
- Ops in EXEC:
  - TLBP: sample s_found/s_index. Hit: Index <= {P=0, index=s_index}. Miss: Index <= 0x8000_0000.
  - TLBR: drive r_index from Index. Load EntryHi <= {vpn2,5'b0,asid}. Load EntryLo0/1 from the pfn/c/d/v of the matching half, with G = r_entry.g in both.
  - TLBWI: tlb_we=1 for exactly this cycle, w_index = Index[IDXW-1:0]. w_entry built from EntryHi/EntryLo0/EntryLo1, with g = EntryLo0.G & EntryLo1.G.
  - TLBWR: as TLBWI but w_index = Random (see Optional Feature).
- Latency: request accepted at cycle T; tlb_we / register update at T+1; resp_valid from T+2. Minimum three cycles per op.
- Simultaneous cp0_we and request accept in IDLE: the write lands at the same edge, so the op observes the new value.
- tlb_we is registered-state-decoded (EXEC && write op), never combinational from req_valid.
- Async reset mid-op: immediate return to IDLE, tlb_we deasserts at once, the pending response is discarded, registers are cleared.

Optional Feature:
- Macro TLB_RANDOM_EN.
- Defined: IDXW-bit Random register.
  - Reset TLBNUM-1; decrements every cycle and wraps 0 -> TLBNUM-1.
  - TLBWR uses the Random value held in the EXEC cycle.
- Undefined: no Random register; TLBWR behaves exactly as TLBWI.

Decomposition:
- Package tlb_pkg:
  - op codes and cp0_sel encodings;
  - w_entry/r_entry field offsets and the 78-bit width;
  - EntryHi/EntryLo/Index bit-position and write-mask constants;
  - FSM state enum.
- One natural sub-module: tlb_random_ctr (Random counter, instantiated only under TLB_RANDOM_EN).

Test Plan:
1. TLBWI write:
   - Stimulus: EntryHi=0x0000_4005, EntryLo0=0x0000_0047, EntryLo1=0x0000_0086, Index=3, then TLBWI at T.
   - Required: tlb_we=1 only at T+1, w_index=3, vpn2=2, asid=5, g=0, pfn0=1, pfn1=2, d/v=1/1 both; resp_valid at T+2.
2. TLBP hit and miss:
   - s_found=1, s_index=3 -> index_o=0x0000_0003.
   - s_found=0 -> index_o=0x8000_0000.
3. TLBR with G set:
   - Stimulus: Index=3, r_entry{vpn2=2, asid=5, g=1, pfn0=1, c0=3, d0=1, v0=1}.
   - Required: r_index=3, entryhi_o=0x0000_4005, entrylo0_o=0x0000_005F, entrylo1_o G bit=1.
4. TLBWR, both builds:
   - With TLB_RANDOM_EN: issue at a cycle where Random=9 in EXEC -> w_index=9; Random wraps 0 -> 15.
   - Without the macro: w_index = Index.
5. Backpressure: hold resp_ready=0 for 5 cycles.
   - resp_valid stays high, req_ready stays 0.
   - A second req_valid is not accepted; a cp0_we to EntryHi is dropped (entryhi_o unchanged).
6. Reset during EXEC of TLBWI: tlb_we falls with reset, no resp_valid ever, all registers read 0, req_ready=1 after release.
